config_chain_loader: RTL and testbench
======================================

Name: config_chain_loader

Overview:
- Master end of the serial configuration chain; the functional-unit ConfigCells and const registers are the receiving end.
- Accepts a configuration bitstream as 32-bit words over a valid/ready interface.
- Serialises the words MSB-first onto the head of the chain (ConfigOut) and produces the chain shift enable.
- Captures the bits leaving the chain tail (ConfigIn) as readback words, so old contents can be verified.

Parameters:
- CHAIN_LEN, 46, total config bits in the chain (4+3+3+3+1+32 for one FU tile).
- WORD_W, 32, input/readback word width.

Ports:
- Config_Clock  in  1  config clock.
- Config_Reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load session.
- word_in  in  WORD_W  bitstream word.
- word_valid  in  1  word_in valid.
- word_ready  out  1  loader accepts word_in this cycle.
- ConfigOut  out  1  serial bit to chain head.
- shift_en  out  1  chain clock enable; the chain shifts on each Config_Clock edge where this is 1.
- ConfigIn  in  1  serial bit from chain tail.
- rb_data  out  WORD_W  readback word.
- rb_valid  out  1  rb_data valid (one-cycle pulse, no backpressure).
- busy  out  1  session in progress.
- done  out  1  one-cycle pulse at end of session.
- err  out  1  sticky: start asserted while busy.

Behaviour:
- Reset (async assert, sync release): state=IDLE, all counters 0, shift reg 0, readback reg 0.
  - All outputs are 0: word_ready, ConfigOut, shift_en, rb_data, rb_valid, busy, done, err.
  - Reset mid-session aborts immediately; chain contents are then undefined and no done is produced.
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE, on start:
  - Go to FETCH.
  - remaining=CHAIN_LEN, rb_cnt=0.
  - Clear err.
  - busy=1 from the next cycle.
- FETCH:
  - word_ready=1 and shift_en=0, so the chain holds.
  - On word_valid&word_ready: sreg<=word_in, word_bits<=min(WORD_W, remaining), go to SHIFT.
  - word_valid low keeps the loader in FETCH indefinitely; ConfigOut stays stable.
- SHIFT:
  - shift_en=1 and ConfigOut=sreg[WORD_W-1], both driven from registers.
  - Each cycle: sreg<<=1, remaining--, word_bits--.
  - ConfigIn is sampled at the same edge into rbreg={rbreg[WORD_W-2:0],ConfigIn}, and rb_cnt++.
  - When word_bits reaches 0:
    - remaining==0 goes to DONE.
    - Otherwise go to FETCH. Each FETCH costs at least one bubble cycle per word.
- Last word: only its upper (CHAIN_LEN mod WORD_W) bits are shifted (all bits if that is 0). Lower bits are ignored.
- Words per session = ceil(CHAIN_LEN/WORD_W).
- Readback:
  - When rb_cnt reaches WORD_W, rb_data<=rbreg (including the bit captured that edge), rb_valid=1 for the next cycle, and rb_cnt resets to 0.
  - On entry to DONE with rb_cnt>0, the partial word is emitted right-justified (zero-filled in the upper bits), rb_valid=1.
  - The first bit read back is the bit that was nearest the tail, i.e. chain contents in shift-out order.
- DONE: done=1 for exactly one cycle, busy=0 from the next cycle, then return to IDLE.
- start while busy (FETCH/SHIFT/DONE): ignored, err<=1 and stays set until the next accepted start.
- Total session length with no stalls: CHAIN_LEN shift cycles + ceil(CHAIN_LEN/WORD_W) FETCH cycles + 1 DONE cycle.

Test Plan:
- Reset:
  - Assert Config_Reset=0 asynchronously with the clock stopped.
  - Required: all outputs 0 immediately, state IDLE after release.
- Basic load, CHAIN_LEN=46, bench model is a 46-flop chain preloaded to 0 with ConfigIn = tail:
  - Stimulus: start, then words 0xA5A5A5A5 and 0xFFFC0000, word_valid always high.
  - ConfigOut sequence is 1,0,1,0,0,1,0,1,... for 32 bits, then 14 ones.
  - shift_en high for exactly 46 cycles, with exactly one low bubble between bit 32 and bit 33.
  - rb_data is 0x00000000, then 0x00000000 (partial word).
  - done pulses once; busy falls the cycle after done.
- Readback:
  - Repeat the identical load.
  - Required: rb_data is 0xA5A5A5A5, then 0x00003FFF.
  - The bench chain model holds the new image.
- Backpressure:
  - Hold word_valid low for 5 cycles while in FETCH between the two words.
  - Required: shift_en=0 and ConfigOut constant for those cycles; the resulting image is identical to the basic-load case.
- Illegal start:
  - Pulse start during SHIFT.
  - Required: err=1, session unaffected (same done timing and data). The next start from IDLE clears err.
- Reset mid-session:
  - Assert Config_Reset=0 after 20 shift cycles.
  - Required: shift_en, busy, word_ready go 0 immediately and no done is produced. A fresh start afterwards completes a full 46-bit load normally.

Source files
------------

// File: rtl/config_chain_loader.sv
// Master end of the serial configuration chain: serialises 32-bit bitstream words MSB-first
// onto the chain head and collects the bits leaving the chain tail as readback words.
module config_chain_loader #(
  parameter int unsigned CHAIN_LEN = 46,
  parameter int unsigned WORD_W    = 32
) (
  input  logic              Config_Clock,
  input  logic              Config_Reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ConfigOut,
  output logic              shift_en,
  input  logic              ConfigIn,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned RemW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned CntW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {StIdle, StFetch, StShift, StDone} state_e;

  state_e            state_q;
  logic [RemW-1:0]   remaining_q;
  logic [CntW-1:0]   word_bits_q;
  logic [CntW-1:0]   rb_cnt_q;
  logic [WORD_W-1:0] sreg_q;
  logic [WORD_W-2:0] rbreg_q;
  logic [WORD_W-1:0] rb_data_q;
  logic              word_ready_q;
  logic              shift_en_q;
  logic              rb_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [WORD_W-1:0] rb_shift;
  logic [WORD_W-1:0] rb_part;
  logic [CntW-1:0]   rb_cnt_inc;
  logic [CntW-1:0]   first_bits;

  always_comb begin
    rb_shift   = {rbreg_q, ConfigIn};
    rb_cnt_inc = rb_cnt_q + CntW'(1);
    // Partial final word: keep only the bits captured this session, right-justified.
    for (int i = 0; i < int'(WORD_W); i++) begin
      rb_part[i] = rb_shift[i] & (i < int'(rb_cnt_inc));
    end
    first_bits = (32'(remaining_q) >= WORD_W) ? CntW'(WORD_W) : CntW'(remaining_q);
  end

  always_ff @(posedge Config_Clock or negedge Config_Reset) begin
    if (!Config_Reset) begin
      state_q      <= StIdle;
      remaining_q  <= '0;
      word_bits_q  <= '0;
      rb_cnt_q     <= '0;
      sreg_q       <= '0;
      rbreg_q      <= '0;
      rb_data_q    <= '0;
      word_ready_q <= 1'b0;
      shift_en_q   <= 1'b0;
      rb_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;
      done_q     <= 1'b0;
      if (start && (state_q != StIdle)) err_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q      <= StFetch;
            remaining_q  <= RemW'(CHAIN_LEN);
            rb_cnt_q     <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b1;
            word_ready_q <= 1'b1;
          end
        end
        StFetch: begin
          if (word_valid) begin
            sreg_q       <= word_in;
            word_bits_q  <= first_bits;
            state_q      <= StShift;
            word_ready_q <= 1'b0;
            shift_en_q   <= 1'b1;
          end
        end
        StShift: begin
          sreg_q      <= sreg_q << 1;
          remaining_q <= remaining_q - RemW'(1);
          word_bits_q <= word_bits_q - CntW'(1);
          rbreg_q     <= rb_shift[WORD_W-2:0];
          if (rb_cnt_inc == CntW'(WORD_W)) begin
            rb_data_q  <= rb_shift;
            rb_valid_q <= 1'b1;
            rb_cnt_q   <= '0;
          end else begin
            rb_cnt_q <= rb_cnt_inc;
          end
          if (word_bits_q == CntW'(1)) begin
            shift_en_q <= 1'b0;
            if (remaining_q == RemW'(1)) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              if (rb_cnt_inc != CntW'(WORD_W)) begin
                rb_data_q  <= rb_part;
                rb_valid_q <= 1'b1;
              end
            end else begin
              state_q      <= StFetch;
              word_ready_q <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign word_ready = word_ready_q;
  assign ConfigOut  = sreg_q[WORD_W-1];
  assign shift_en   = shift_en_q;
  assign rb_data    = rb_data_q;
  assign rb_valid   = rb_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader with a 46-flop chain model fed from ConfigOut.
module tb_config_chain_loader;

  localparam int unsigned CHAIN_LEN = 46;
  localparam int unsigned WORD_W    = 32;
  localparam logic [45:0] IMAGE     = {32'hA5A5A5A5, 14'h3FFF};

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic        ConfigOut;
  logic        shift_en;
  logic        ConfigIn;
  logic [31:0] rb_data;
  logic        rb_valid;
  logic        busy;
  logic        done;
  logic        err;

  config_chain_loader #(
    .CHAIN_LEN(CHAIN_LEN),
    .WORD_W   (WORD_W)
  ) dut (
    .Config_Clock(clk),
    .Config_Reset(rst_n),
    .start       (start),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .ConfigOut   (ConfigOut),
    .shift_en    (shift_en),
    .ConfigIn    (ConfigIn),
    .rb_data     (rb_data),
    .rb_valid    (rb_valid),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Chain model: head is bit 0, tail is bit 45.
  logic [45:0] chain = '0;
  assign ConfigIn = chain[45];
  always @(posedge clk) if (shift_en) chain <= {chain[44:0], ConfigOut};

  // Monitor counters, written only here.
  int          sh_total = 0, gap_total = 0, done_total = 0, busy_total = 0;
  int          unst_total = 0, busy_late = 0, sess_sh = 0;
  logic        prev_gap = 1'b0, prev_co = 1'b0, prev_done = 1'b0;
  logic [45:0] co_hist = '0;
  logic [31:0] rbq[$];
  logic        gap_now;
  assign gap_now = busy && !shift_en && (sess_sh > 0) && (sess_sh < int'(CHAIN_LEN));

  always @(negedge clk) begin
    if (shift_en) begin
      sh_total <= sh_total + 1;
      co_hist  <= {co_hist[44:0], ConfigOut};
    end
    sess_sh <= !busy ? 0 : (shift_en ? sess_sh + 1 : sess_sh);
    if (gap_now) gap_total <= gap_total + 1;
    if (gap_now && prev_gap && (ConfigOut !== prev_co)) unst_total <= unst_total + 1;
    prev_gap  <= gap_now;
    prev_co   <= ConfigOut;
    if (done) done_total <= done_total + 1;
    if (prev_done && busy) busy_late <= busy_late + 1;
    prev_done <= done;
    if (busy) busy_total <= busy_total + 1;
    if (rb_valid) rbq.push_back(rb_data);
  end

  int n_checks = 0;
  int n_bad    = 0;
  int s_sh, s_gap, s_done, s_busy, s_unst, s_late, s_rbq;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_sh   = sh_total;
    s_gap  = gap_total;
    s_done = done_total;
    s_busy = busy_total;
    s_unst = unst_total;
    s_late = busy_late;
    s_rbq  = rbq.size();
  endtask

  task automatic load(input int stall, input bit bad_start);
    int t;
    @(posedge clk); #1;
    start = 1'b1; word_valid = 1'b1; word_in = 32'hA5A5A5A5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    word_in = 32'hFFFC0000;
    if (stall > 0) word_valid = 1'b0;
    if (bad_start) begin
      repeat (10) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    t = 0;
    while (!word_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check_val("fetch_reached", t < 100, 1);
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1 word_valid = 1'b1;
    end
    t = 0;
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_val("done_reached", t < 200, 1);
    word_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_session(input string nm, input int stall, input logic [31:0] rb0,
                               input logic [31:0] rb1, input bit chk_rb);
    check_val({nm, "_shifts"}, sh_total - s_sh, CHAIN_LEN);
    check_val({nm, "_bubbles"}, gap_total - s_gap, 1 + stall);
    check_val({nm, "_done_cnt"}, done_total - s_done, 1);
    check_val({nm, "_busy_cycles"}, busy_total - s_busy, 49 + stall);
    check_val({nm, "_busy_after_done"}, busy_late - s_late, 0);
    check_val({nm, "_co_stable"}, unst_total - s_unst, 0);
    check_val({nm, "_co_seq"}, co_hist, IMAGE);
    check_val({nm, "_chain"}, chain, IMAGE);
    check_val({nm, "_rb_words"}, rbq.size() - s_rbq, 2);
    if (chk_rb) begin
      check_val({nm, "_rb0"}, rbq[s_rbq], rb0);
      check_val({nm, "_rb1"}, rbq[s_rbq + 1], rb1);
    end
  endtask

  initial begin
    start = 1'b0; word_valid = 1'b0; word_in = '0; rst_n = 1'b1;
    // Reset with clock stopped.
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_word_ready", word_ready, 0);
    check_val("rst_configout", ConfigOut, 0);
    check_val("rst_shift_en", shift_en, 0);
    check_val("rst_rb_data", rb_data, 0);
    check_val("rst_rb_valid", rb_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", err, 0);
    #5 clk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_val("idle_busy", busy, 0);
    check_val("idle_ready", word_ready, 0);
    check_val("idle_shift_en", shift_en, 0);

    snap(); load(0, 1'b0);
    check_session("basic", 0, 32'h0, 32'h0, 1'b1);

    snap(); load(0, 1'b0);
    check_session("readback", 0, 32'hA5A5A5A5, 32'h00003FFF, 1'b1);

    snap(); load(5, 1'b0);
    check_session("stall", 5, 32'hA5A5A5A5, 32'h00003FFF, 1'b1);

    snap(); load(0, 1'b1);
    check_session("bad_start", 0, 32'hA5A5A5A5, 32'h00003FFF, 1'b1);
    check_val("err_sticky", err, 1);

    // Accepted start clears err; then abort with reset after 20 shifts.
    snap();
    @(posedge clk); #1;
    start = 1'b1; word_valid = 1'b1; word_in = 32'hA5A5A5A5;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("err_cleared", err, 0);
    @(posedge clk); #1;
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("abort_shift_en", shift_en, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_ready", word_ready, 0);
    word_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("abort_no_done", done_total - s_done, 0);
    check_val("abort_shifts", sh_total - s_sh, 20);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    snap(); load(0, 1'b0);
    check_session("after_abort", 0, 32'h0, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
